demux_1x8_sched: RTL and testbench
==================================

# demux_1x8_sched

Round-robin scheduler that shares the 1x8 demultiplexer among eight requesting channels. Each granted channel owns the demux for a fixed dwell window. During that window the serial input bit is routed to its output line. The block owns the demux's `sel`/`addr` controls, instantiates `demux_1x8` directly, and sits between the channel request logic and the eight downstream consumers.

## Interface
- `DWELL`, default 4: cycles per grant; legal range 1..255.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: scheduler enable; gates new grants only.
- `req` input 8: per-channel request levels; bit i is channel i.
- `data_in` input 1: serial bit routed to the granted channel.
- `ch_mask` input 8: per-channel allow mask (only with `DEMUX_SCHED_MASK_EN`).
- `sel` output 1: demux enable; high while a grant is active.
- `addr` output 3: demux address; the granted channel index.
- `grant` output 8: one-hot grant; zero when idle.
- `done` output 1: single-cycle pulse in the last cycle of each dwell.
- `busy` output 1: equals `sel`.
- `out` output 8: demux outputs.

## Operation
- Effective request: `eff_req = req` (with the macro: `req & ch_mask`).
- **States:** IDLE and ROUTE.
- **IDLE:**
  - `sel`=0, `grant`=0.
  - If `en && |eff_req`: pick the next channel, load `addr`/`grant`, clear the dwell counter, go to ROUTE.
- **Round-robin pick:**
  - Search order is `last+1`, `last+2`, … mod 8. The first set bit of `eff_req` wins.
  - `last` updates to the winner.
  - After reset `last`=7, so channel 0 has first priority.
- **ROUTE:**
  - `sel`=1; the counter increments each cycle.
  - When the counter reaches `DWELL-1`, `done`=1 for that cycle. At the next edge:
    - If `en && |eff_req`: re-arbitrate and stay in ROUTE. Grants run back-to-back with no idle cycle.
    - Otherwise: go to IDLE.
- **Non-preemptive:**
  - Dropping `req[addr]` mid-dwell does not shorten the grant.
  - Deasserting `en` mid-dwell does not shorten the grant.
  - Changing `ch_mask` mid-dwell does not shorten the grant.
- **Single requester:** the same channel is re-granted back-to-back indefinitely.
- **Output routing:** `out = sel ? (data_in << addr) : 8'b0`. `data_in` is not registered.
- **Counter:** 8 bits, compared against `DWELL-1`. With `DWELL`=1, `done` is high in every ROUTE cycle.
- **Reset mid-operation:**
  - The next edge forces IDLE, `last`=7 and counter=0, regardless of state or inputs.
  - Reset has priority over every other event.

## Timing
- **Reset values:**
  - `sel`=0, `addr`=3'b000, `grant`=8'h00, `done`=0, `busy`=0, `out`=8'h00.
  - Internal: `last`=7, counter=0.
- **Registered outputs:** `sel`, `addr` and `grant` are registered.
- **Combinational outputs:**
  - `done` decodes from the state and counter.
  - `out` decodes combinationally from registered `sel`/`addr` and live `data_in`.
- **Grant latency:** `eff_req` sampled at edge k from IDLE gives `sel`=1 and a valid `addr`/`grant` after edge k.
- **Dwell length:** `sel` is high for exactly `DWELL` cycles per grant.
- **Back-to-back:** `addr` changes at the edge immediately following the `done` cycle.
- **Grant rate:** one grant decision per dwell; no decision is made during a dwell.

## Configuration
- **Macro:** `DEMUX_SCHED_MASK_EN`.
- **Defined:**
  - The `ch_mask` port exists.
  - Masked channels are never granted, even if requesting.
  - An all-zero mask keeps the block in IDLE.
- **Undefined:**
  - No `ch_mask` port.
  - `eff_req = req`; every requesting channel is eligible.

## Structure
- **Shared package `demux_sched_pkg`:**
  - `N_CH`=8, `ADDR_W`=3.
  - State encodings `ST_IDLE`=0, `ST_ROUTE`=1.
  - Reset pointer value `LAST_RST`=7.
- **Sub-module `demux_1x8`:** instantiated unchanged, driven by registered `sel`/`addr` and by `data_in`.
- **Round-robin pick:** a local function inside `demux_1x8_sched`; no separate module.

## Test plan
1. **Reset:** `rst`=1 for 3 cycles with `req`=8'hFF, `en`=1.
   - During reset: all outputs 0.
   - At the first edge after release: `grant`=8'h01, `addr`=0.
2. **Two requesters:** `DWELL`=4, `req`=8'b0010_0100, `data_in`=1.
   - Channel 2 for 4 cycles (`out`=8'h04), then channel 5 for 4 cycles (`out`=8'h20), then channel 2 again.
   - `sel` never drops; `done` pulses every 4th cycle.
3. **All requesting:** `req`=8'hFF.
   - Grant order is 0,1,2,…,7,0; each `grant` stays one-hot for 4 cycles.
   - `data_in`=0 gives `out`=0 while `sel`=1.
4. **Request drop:** `req`=8'h01, cleared one cycle after the grant.
   - Channel 0 held the full 4 cycles with `done` in cycle 4.
   - Then IDLE: `sel`=0, `grant`=0.
5. **Enable drop and reset:**
   - `en` dropped in cycle 2 of a dwell: the dwell completes, then IDLE.
   - `rst` asserted in cycle 2 of a dwell: `sel`=0 after the next edge, and the next grant is channel 0.
6. **Mask (`DEMUX_SCHED_MASK_EN`):** `ch_mask`=8'hFE, `req`=8'h03.
   - Only channel 1 is granted, repeatedly.
   - Without the macro, channels 0 and 1 alternate.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared constants and state encoding for the round-robin 1x8 demux scheduler.
package demux_sched_pkg;

  localparam int unsigned N_CH   = 8;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] LAST_RST = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ROUTE = 1'b1
  } state_e;

endpackage

// File: rtl/demux_1x8.sv
// 1-to-8 demultiplexer: routes din to out[addr] while sel is high, else all zero.
module demux_1x8 (
  input  logic       sel,
  input  logic [2:0] addr,
  input  logic       din,
  output logic [7:0] out
);

  always_comb begin
    out = '0;
    if (sel) out[addr] = din;
  end

endmodule

// File: rtl/demux_1x8_sched.sv
// Round-robin scheduler granting the 1x8 demux to one channel per DWELL-cycle window.
// Optional per-channel allow mask (ch_mask port) when DEMUX_SCHED_MASK_EN is defined.
module demux_1x8_sched
  import demux_sched_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       data_in,
`ifdef DEMUX_SCHED_MASK_EN
  input  logic [7:0] ch_mask,
`endif
  output logic       sel,
  output logic [2:0] addr,
  output logic [7:0] grant,
  output logic       done,
  output logic       busy,
  output logic [7:0] out
);

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [N_CH-1:0]     grant_q;
  logic                sel_q;
  logic [7:0]          cnt_q;
  logic [N_CH-1:0]     eff_req;
  logic [ADDR_W-1:0]   pick_d;
  logic                arb_ok;

  // First set bit of r searching last+1, last+2, ... wrapping mod N_CH.
  function automatic logic [ADDR_W-1:0] rr_pick(input logic [N_CH-1:0]   r,
                                                input logic [ADDR_W-1:0] last);
    logic [ADDR_W-1:0] idx;
    logic              found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = last + ADDR_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef DEMUX_SCHED_MASK_EN
  assign eff_req = req & ch_mask;
`else
  assign eff_req = req;
`endif

  always_comb begin
    pick_d = rr_pick(eff_req, last_q);
    arb_ok = en && (|eff_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      addr_q  <= '0;
      grant_q <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_ok) begin
            state_q <= ST_ROUTE;
            last_q  <= pick_d;
            addr_q  <= pick_d;
            grant_q <= N_CH'(1) << pick_d;
            sel_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_ROUTE: begin
          // Arbitration only happens at the dwell boundary, so grants are non-preemptive.
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (arb_ok) begin
              last_q  <= pick_d;
              addr_q  <= pick_d;
              grant_q <= N_CH'(1) << pick_d;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              sel_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel   = sel_q;
  assign busy  = sel_q;
  assign addr  = addr_q;
  assign grant = grant_q;
  assign done  = (state_q == ST_ROUTE) && (cnt_q == CNT_LAST);

  demux_1x8 u_demux (
    .sel  (sel_q),
    .addr (addr_q),
    .din  (data_in),
    .out  (out)
  );

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Directed self-checking bench for demux_1x8_sched with DWELL=4.
module tb_demux_1x8_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       data_in = 1'b0;
  logic [7:0] ch_mask = 8'hFF;
  logic       sel, done, busy;
  logic [2:0] addr;
  logic [7:0] grant, out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_1x8_sched #(.DWELL(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .data_in (data_in),
`ifdef DEMUX_SCHED_MASK_EN
    .ch_mask (ch_mask),
`endif
    .sel     (sel),
    .addr    (addr),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .out     (out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'hFF; en = 1'b1; data_in = 1'b1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({sel, addr, grant, done, busy, out} !== 21'h0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got sel=%b addr=%0d grant=%h done=%b busy=%b out=%h want all zero",
                 i, sel, addr, grant, done, busy, out);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 8'h01 || addr !== 3'd0 || sel !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_grant got grant=%h addr=%0d sel=%b want grant=01 addr=0 sel=1", grant, addr, sel);
    end
  endtask

  task automatic test_two_requesters();
    logic [2:0] ch;
    req = 8'b0010_0100; en = 1'b1; data_in = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      ch = ((c / 4) % 2 == 0) ? 3'd2 : 3'd5;
      n_cmp++;
      if (sel !== 1'b1 || busy !== 1'b1 || addr !== ch || out !== (8'h01 << ch)) begin
        n_err++;
        $display("FAIL two_req_route cyc=%0d got sel=%b busy=%b addr=%0d out=%h want sel=1 addr=%0d out=%h",
                 c, sel, busy, addr, out, ch, 8'h01 << ch);
      end
      n_cmp++;
      if (done !== (c % 4 == 3)) begin
        n_err++;
        $display("FAIL two_req_done cyc=%0d got %b want %b", c, done, (c % 4 == 3));
      end
    end
  endtask

  task automatic test_all_requesting();
    logic [2:0] ch;
    req = 8'hFF; en = 1'b1; data_in = 1'b0;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      tick();
      ch = 3'((c / 4) % 8);
      n_cmp++;
      if (sel !== 1'b1 || grant !== (8'h01 << ch) || out !== 8'h00) begin
        n_err++;
        $display("FAIL all_req cyc=%0d got sel=%b grant=%h out=%h want sel=1 grant=%h out=00",
                 c, sel, grant, out, 8'h01 << ch);
      end
    end
  endtask

  task automatic test_req_drop();
    req = 8'h01; en = 1'b1; data_in = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) req = 8'h00;
      n_cmp++;
      if (sel !== 1'b1 || grant !== 8'h01 || done !== (c == 3) || out !== 8'h01) begin
        n_err++;
        $display("FAIL req_drop_hold cyc=%0d got sel=%b grant=%h done=%b out=%h want sel=1 grant=01 done=%b out=01",
                 c, sel, grant, done, out, (c == 3));
      end
    end
    tick();
    n_cmp++;
    if (sel !== 1'b0 || grant !== 8'h00 || done !== 1'b0 || out !== 8'h00) begin
      n_err++;
      $display("FAIL req_drop_idle got sel=%b grant=%h done=%b out=%h want 0/00/0/00", sel, grant, done, out);
    end
  endtask

  task automatic test_en_drop_and_reset();
    req = 8'h01; en = 1'b1; data_in = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) en = 1'b0;
      n_cmp++;
      if (sel !== 1'b1 || grant !== 8'h01 || done !== (c == 3)) begin
        n_err++;
        $display("FAIL en_drop_hold cyc=%0d got sel=%b grant=%h done=%b want sel=1 grant=01 done=%b",
                 c, sel, grant, done, (c == 3));
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (sel !== 1'b0 || grant !== 8'h00) begin
        n_err++;
        $display("FAIL en_drop_idle cyc=%0d got sel=%b grant=%h want 0/00", c, sel, grant);
      end
    end
    // Reset in cycle 2 of channel 1's dwell
    req = 8'hFF; en = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    n_cmp++;
    if (grant !== 8'h02) begin
      n_err++;
      $display("FAIL rst_mid_pre got grant=%h want 02", grant);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (sel !== 1'b0 || grant !== 8'h00 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_idle got sel=%b grant=%h done=%b want 0/00/0", sel, grant, done);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 8'h01 || addr !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid_regrant got grant=%h addr=%0d want 01/0", grant, addr);
    end
  endtask

  task automatic test_mask();
    logic [2:0] ch;
    req = 8'h03; en = 1'b1; data_in = 1'b1; ch_mask = 8'hFE;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
`ifdef DEMUX_SCHED_MASK_EN
      ch = 3'd1;
`else
      ch = ((c / 4) % 2 == 0) ? 3'd0 : 3'd1;
`endif
      n_cmp++;
      if (sel !== 1'b1 || grant !== (8'h01 << ch)) begin
        n_err++;
        $display("FAIL mask cyc=%0d got sel=%b grant=%h want sel=1 grant=%h", c, sel, grant, 8'h01 << ch);
      end
    end
`ifdef DEMUX_SCHED_MASK_EN
    ch_mask = 8'h00;
    do_reset();
    tick();
    n_cmp++;
    if (sel !== 1'b0 || grant !== 8'h00) begin
      n_err++;
      $display("FAIL mask_zero got sel=%b grant=%h want 0/00", sel, grant);
    end
`endif
    ch_mask = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_two_requesters();
    test_all_requesting();
    test_req_drop();
    test_en_drop_and_reset();
    test_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
